// File: rtl/sdram_arb_pkg.sv
// Shared types and AHB-Lite encodings for the two-port SDRAM arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } arb_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Requesters may send size 3; the bus only ever sees up to a word.
  function automatic logic [1:0] eff_size(input logic [1:0] s);
    return (s == 2'd3) ? SIZE_WORD : s;
  endfunction

  function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [1:0] s);
    case (s)
      SIZE_WORD: return {a[31:2], 2'b00};
      SIZE_HALF: return {a[31:1], 1'b0};
      default:   return a;
    endcase
  endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Winner selection between the CPU port (0) and the SID fetch port (1),
// with a starvation counter that forces port 0 through after a run of port-1 wins.
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic grant_en,
  output logic grant_port
);

  logic [3:0] starve_q;
  logic [3:0] starve_d;

  always_comb begin
    grant_port = req1 && !(req0 && (starve_q >= 4'(STARVE_LIMIT)));
    starve_d   = starve_q;
    // Only a real grant moves the counter; bus activity in between is invisible to it.
    if (grant_en) begin
      if (grant_port && req0) begin
        starve_d = (starve_q == 4'd15) ? 4'd15 : starve_q + 4'd1;
      end else begin
        starve_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/sdram_ahb_arbiter.sv
// Two-port request/acknowledge front end issuing AHB-Lite SINGLE transfers
// to the shared SDRAM slave; port 1 has priority, port 0 is starvation-protected.
module sdram_ahb_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int          ADDR_W       = 23,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic              HCLK,
  input  logic              HRESETN,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [1:0]        SIZE0,
  input  logic [1:0]        SIZE1,
  input  logic [31:0]       WDATA0,
  input  logic [31:0]       WDATA1,
  output logic              ACK0,
  output logic              ACK1,
  output logic              ERR0,
  output logic              ERR1,
  output logic [31:0]       RDATA0,
  output logic [31:0]       RDATA1,
  output logic              HSEL,
  output logic [31:0]       HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [31:0]       HWDATA,
  output logic              HREADYIN,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic [1:0]        HRESP
);

  arb_state_t  state_q, state_d;
  logic        gnt_q, gnt_d;
  logic [31:0] wdata_q, wdata_d;
  logic        hsel_q, hsel_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] haddr_q, haddr_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic        grant_en;
  logic        pick;
  logic [1:0]  sel_size;
  logic        resp_err;

  assign grant_en = (state_q == ST_IDLE) && (REQ0 || REQ1);
  assign resp_err = (HRESP != HRESP_OKAY);
  assign sel_size = eff_size(pick ? SIZE1 : SIZE0);

  sdram_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk        (HCLK),
    .rst_n      (HRESETN),
    .req0       (REQ0),
    .req1       (REQ1),
    .grant_en   (grant_en),
    .grant_port (pick)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    wdata_d  = wdata_q;
    hsel_d   = hsel_q;
    htrans_d = htrans_q;
    hwrite_d = hwrite_q;
    haddr_d  = haddr_q;
    hsize_d  = hsize_q;
    hwdata_d = hwdata_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = err0_q;
    err1_d   = err1_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_en) begin
          state_d  = ST_ADDR;
          gnt_d    = pick;
          hsel_d   = 1'b1;
          htrans_d = HTRANS_NONSEQ;
          hwrite_d = pick ? WE1 : WE0;
          hsize_d  = {1'b0, sel_size};
          wdata_d  = pick ? WDATA1 : WDATA0;
          haddr_d  = align_addr(BASE_ADDR | 32'(pick ? ADDR1 : ADDR0), sel_size);
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          state_d  = ST_DATA;
          hsel_d   = 1'b0;
          htrans_d = HTRANS_IDLE;
          hwdata_d = wdata_q;
        end
      end
      ST_DATA: begin
        // An ERROR seen while HREADY is low is the first half of the two-cycle response.
        if (HREADY) begin
          state_d = ST_RESP;
          if (gnt_q) begin
            ack1_d = 1'b1;
            err1_d = resp_err;
            if (!hwrite_q && !resp_err) rdata1_d = HRDATA;
          end else begin
            ack0_d = 1'b1;
            err0_d = resp_err;
            if (!hwrite_q && !resp_err) rdata0_d = HRDATA;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 1'b0;
      wdata_q  <= '0;
      hsel_q   <= 1'b0;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
      haddr_q  <= '0;
      hsize_q  <= '0;
      hwdata_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      wdata_q  <= wdata_d;
      hsel_q   <= hsel_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      haddr_q  <= haddr_d;
      hsize_q  <= hsize_d;
      hwdata_q <= hwdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign ACK0     = ack0_q;
  assign ACK1     = ack1_q;
  assign ERR0     = err0_q;
  assign ERR1     = err1_q;
  assign RDATA0   = rdata0_q;
  assign RDATA1   = rdata1_q;
  assign HSEL     = hsel_q;
  assign HADDR    = haddr_q;
  assign HTRANS   = htrans_q;
  assign HWRITE   = hwrite_q;
  assign HSIZE    = hsize_q;
  assign HBURST   = HBURST_SINGLE;
  assign HWDATA   = hwdata_q;
  assign HREADYIN = HREADY;

endmodule

// File: tb/tb_sdram_ahb_arbiter.sv
// Randomized transaction-level bench for sdram_ahb_arbiter with a reference
// model of arbitration, alignment, latency and read-data bookkeeping.
module tb_sdram_ahb_arbiter;

  localparam int          ADDR_W = 23;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          LIMIT  = 4;

  logic              HCLK = 1'b0;
  logic              HRESETN;
  logic              ACK0, ACK1, ERR0, ERR1;
  logic [31:0]       RDATA0, RDATA1;
  logic              HSEL, HWRITE, HREADYIN;
  logic [31:0]       HADDR, HWDATA;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE, HBURST;
  logic [31:0]       HRDATA;
  logic              HREADY;
  logic [1:0]        HRESP;

  logic              req_v   [2];
  logic              we_v    [2];
  logic [ADDR_W-1:0] addr_v  [2];
  logic [1:0]        size_v  [2];
  logic [31:0]       wdata_v [2];

  int          vectors     = 0;
  int          miscompares = 0;
  int          streak      = 0;
  int          xfer_no     = 0;
  logic [31:0] rdata_m [2];

  always #5 HCLK = ~HCLK;

  sdram_ahb_arbiter #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .STARVE_LIMIT(LIMIT)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .REQ0(req_v[0]), .REQ1(req_v[1]), .WE0(we_v[0]), .WE1(we_v[1]),
    .ADDR0(addr_v[0]), .ADDR1(addr_v[1]), .SIZE0(size_v[0]), .SIZE1(size_v[1]),
    .WDATA0(wdata_v[0]), .WDATA1(wdata_v[1]),
    .ACK0(ACK0), .ACK1(ACK1), .ERR0(ERR0), .ERR1(ERR1),
    .RDATA0(RDATA0), .RDATA1(RDATA1),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HREADYIN(HREADYIN),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_haddr(input logic [ADDR_W-1:0] a, input logic [1:0] s);
    int unsigned v;
    v = 32'(a);
    if (s >= 2)      v = v - (v % 4);
    else if (s == 1) v = v - (v % 2);
    return BASE | v;
  endfunction

  task automatic new_fields(input int p);
    we_v[p]    = 1'($urandom_range(0, 1));
    addr_v[p]  = ADDR_W'($urandom);
    size_v[p]  = 2'($urandom_range(0, 3));
    wdata_v[p] = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_hsel"},   32'(HSEL),   0);
    check_val({tag, "_htrans"}, 32'(HTRANS), 0);
    check_val({tag, "_haddr"},  HADDR,       0);
    check_val({tag, "_hwrite"}, 32'(HWRITE), 0);
    check_val({tag, "_hsize"},  32'(HSIZE),  0);
    check_val({tag, "_hwdata"}, HWDATA,      0);
    check_val({tag, "_ack"},    32'({ACK1, ACK0}), 0);
    check_val({tag, "_err"},    32'({ERR1, ERR0}), 0);
    check_val({tag, "_rdata0"}, RDATA0, 0);
    check_val({tag, "_rdata1"}, RDATA1, 0);
  endtask

  // Entered just after the edge where the request became visible (cycle 0, IDLE).
  task automatic run_xfer(input int aw, input int dw, input bit err_fin, input bit err_first,
                          input logic [31:0] rd, output int won);
    int          w;
    logic [31:0] ea;
    logic [1:0]  es;
    @(negedge HCLK);
    check_val("idle_htrans", 32'(HTRANS), 0);
    check_val("idle_hsel", 32'(HSEL), 0);
    w = (req_v[1] && !(req_v[0] && streak >= LIMIT)) ? 1 : 0;
    streak = (w == 1 && req_v[0]) ? ((streak < 15) ? streak + 1 : 15) : 0;
    ea = exp_haddr(addr_v[w], size_v[w]);
    es = (size_v[w] == 2'd3) ? 2'd2 : size_v[w];
    for (int c = 0; c <= aw; c++) begin
      @(posedge HCLK); #1;
      HREADY = (c == aw); HRESP = 2'b00; HRDATA = $urandom;
      @(negedge HCLK);
      check_val("a_htrans", 32'(HTRANS), 32'h2);
      check_val("a_hsel", 32'(HSEL), 1);
      check_val("a_haddr", HADDR, ea);
      check_val("a_hsize", 32'(HSIZE), 32'(es));
      check_val("a_hwrite", 32'(HWRITE), 32'(we_v[w]));
      check_val("a_hburst", 32'(HBURST), 0);
      check_val("a_ack", 32'({ACK1, ACK0}), 0);
    end
    for (int c = 0; c <= dw; c++) begin
      @(posedge HCLK); #1;
      HREADY = (c == dw);
      if (c == dw)                  HRESP = err_fin ? 2'b01 : 2'b00;
      else if (c == 0 && err_first) HRESP = 2'b01;
      else                          HRESP = 2'b00;
      HRDATA = (c == dw) ? rd : $urandom;
      @(negedge HCLK);
      check_val("d_htrans", 32'(HTRANS), 0);
      check_val("d_hsel", 32'(HSEL), 0);
      check_val("d_ack", 32'({ACK1, ACK0}), 0);
      check_val("d_hreadyin", 32'(HREADYIN), 32'(HREADY));
      if (we_v[w]) check_val("d_hwdata", HWDATA, wdata_v[w]);
    end
    @(posedge HCLK); #1;
    HREADY = 1'b1; HRESP = 2'b00; HRDATA = $urandom;
    if (!we_v[w] && !err_fin) rdata_m[w] = rd;
    @(negedge HCLK);
    check_val("r_ack0", 32'(ACK0), 32'(w == 0));
    check_val("r_ack1", 32'(ACK1), 32'(w == 1));
    check_val("r_err", 32'(w == 1 ? ERR1 : ERR0), 32'(err_fin));
    check_val("r_rdata0", RDATA0, rdata_m[0]);
    check_val("r_rdata1", RDATA1, rdata_m[1]);
    $display("xfer %0d: port%0d %s addr=%h size=%0d aw=%0d dw=%0d err=%0d rdata0=%h rdata1=%h",
             xfer_no, w, we_v[w] ? "WR" : "RD", ea, es, aw, dw, err_fin, RDATA0, RDATA1);
    xfer_no++;
    won = w;
  endtask

  int won;
  int seq_exp [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    HRESETN = 1'b0; HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0;
    for (int p = 0; p < 2; p++) begin
      req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = '0; size_v[p] = '0; wdata_v[p] = '0;
      rdata_m[p] = '0;
    end
    repeat (2) @(negedge HCLK);
    check_all_zero("rst");
    @(posedge HCLK); #1;
    HRESETN = 1'b1;

    // Single word read on port 1
    @(posedge HCLK); #1;
    req_v[1] = 1; we_v[1] = 0; addr_v[1] = 23'h000104; size_v[1] = 2;
    run_xfer(0, 0, 0, 0, 32'hDEADBEEF, won);
    check_val("single_rdata1", RDATA1, 32'hDEADBEEF);
    @(posedge HCLK); #1;
    req_v[1] = 0;

    // Halfword write on port 0
    req_v[0] = 1; we_v[0] = 1; addr_v[0] = 23'h000033; size_v[0] = 1; wdata_v[0] = 32'h12341234;
    run_xfer(0, 0, 0, 0, 32'hCAFEF00D, won);
    @(posedge HCLK); #1;
    req_v[0] = 0;

    // Wait states: ACK lands at cycle 8
    req_v[1] = 1; we_v[1] = 0; addr_v[1] = 23'h012346; size_v[1] = 2;
    run_xfer(2, 3, 0, 0, 32'hA5A55A5A, won);
    @(posedge HCLK); #1;

    // Two-cycle ERROR response on a read
    addr_v[1] = 23'h000200;
    run_xfer(0, 1, 1, 1, 32'h0BADF00D, won);
    check_val("err_rdata1_kept", RDATA1, 32'hA5A55A5A);
    @(posedge HCLK); #1;

    // Starvation: both requesting back to back
    new_fields(0); new_fields(1);
    req_v[0] = 1; req_v[1] = 1;
    for (int i = 0; i < 10; i++) begin
      run_xfer(0, 0, 0, 0, $urandom, won);
      check_val("starve_seq", 32'(won), 32'(seq_exp[i]));
      @(posedge HCLK); #1;
      new_fields(won);
    end
    req_v[0] = 0; req_v[1] = 0;
    @(posedge HCLK); #1;

    // Randomized traffic
    new_fields(0); new_fields(1);
    req_v[0] = 1'($urandom_range(0, 1));
    req_v[1] = ~req_v[0] | 1'($urandom_range(0, 1));
    for (int i = 0; i < 60; i++) begin
      int  aw, dw;
      bit  ef, e1;
      aw = $urandom_range(0, 2);
      dw = $urandom_range(0, 2);
      ef = ($urandom_range(0, 7) == 0);
      e1 = ef && (dw > 0) && ($urandom_range(0, 1) == 1);
      run_xfer(aw, dw, ef, e1, $urandom, won);
      @(posedge HCLK); #1;
      req_v[won] = 1'($urandom_range(0, 1));
      if (req_v[won]) new_fields(won);
      if (!req_v[1 - won] && ($urandom_range(0, 1) == 1)) begin
        req_v[1 - won] = 1; new_fields(1 - won);
      end
      if (!req_v[0] && !req_v[1]) begin
        req_v[won] = 1; new_fields(won);
      end
    end
    req_v[0] = 0; req_v[1] = 0;
    @(posedge HCLK); #1;

    // Reset while waiting in the data phase
    req_v[1] = 1; we_v[1] = 0; addr_v[1] = 23'h000400; size_v[1] = 2;
    @(posedge HCLK); #1;
    HREADY = 1'b1;
    @(posedge HCLK); #1;
    HREADY = 1'b0;
    @(negedge HCLK);
    check_val("pre_rst_htrans", 32'(HTRANS), 0);
    #2;
    HRESETN = 1'b0;
    #1;
    check_all_zero("async_rst");
    streak = 0; rdata_m[0] = '0; rdata_m[1] = '0;
    req_v[1] = 0;
    req_v[0] = 1; we_v[0] = 0; addr_v[0] = 23'h000777; size_v[0] = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      check_val("rst_no_ack", 32'({ACK1, ACK0}), 0);
    end
    @(posedge HCLK); #1;
    HRESETN = 1'b1; HREADY = 1'b1;
    run_xfer(0, 0, 0, 0, 32'h13579BDF, won);
    check_val("post_rst_port", 32'(won), 0);
    @(posedge HCLK); #1;
    req_v[0] = 0;
    repeat (2) @(posedge HCLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdram_ahb_arbiter.md
Name: sdram_ahb_arbiter

Overview:
- Two-port request/acknowledge arbiter and AHB-Lite master that shares the single SDRAM AHB slave between two requesters.
- Port 0 is the host/CPU bridge. Port 1 is the SID sample/audio fetch engine.
- Each accepted request becomes one AHB SINGLE transfer. The arbiter waits for the slave's HREADY/HRESP and returns a registered acknowledge with read data.
- Port 1 has priority. A starvation counter guarantees port 0 service.

Parameters:
- ADDR_W, 23, byte-address width of requester ports (8 MB SDRAM).
- BASE_ADDR, 32'h0000_0000, SDRAM window base; ORed into HADDR.
- STARVE_LIMIT, 4, consecutive port-1 grants while port 0 waits before port 0 is forced to win; range 1..15.

Ports:
- HCLK  in  1  system clock; all logic on rising edge
- HRESETN  in  1  asynchronous active-low reset
- REQ0, REQ1  in  1 each  request; held with its fields stable until the matching ACK
- WE0, WE1  in  1 each  1 = write, 0 = read
- ADDR0, ADDR1  in  ADDR_W each  byte address
- SIZE0, SIZE1  in  2 each  0 = byte, 1 = halfword, 2 = word (3 treated as 2)
- WDATA0, WDATA1  in  32 each  write data, lane-replicated by the requester
- ACK0, ACK1  out  1 each  one-cycle completion pulse
- ERR0, ERR1  out  1 each  valid with ACK; 1 = slave ERROR response
- RDATA0, RDATA1  out  32 each  read data, valid with ACK; held until the next ACK on that port
- HSEL  out  1  slave select
- HADDR  out  32  BASE_ADDR | aligned address
- HTRANS  out  2  IDLE = 2'b00 or NONSEQ = 2'b10
- HWRITE  out  1  transfer direction
- HSIZE  out  3  {1'b0, size}
- HBURST  out  3  always 3'b000 (SINGLE)
- HWDATA  out  32  write data, data phase
- HREADYIN  out  1  equals the HREADY input (slave feedback)
- HRDATA  in  32  slave read data
- HREADY  in  1  slave ready
- HRESP  in  2  slave response; 2'b00 OKAY, 2'b01 ERROR

Behaviour:
- Reset values: all outputs 0; HTRANS = IDLE; state = IDLE; starvation counter = 0.
- Reset is asynchronous. Asserting it mid-transfer aborts immediately and returns to IDLE. No ACK is issued; the requester must reissue after reset.
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - If any REQ is high, arbitrate and latch the winner's WE/ADDR/SIZE/WDATA and the grant index; go to ADDR.
  - Otherwise stay in IDLE with HSEL = 0 and HTRANS = IDLE.
- Arbitration:
  - Only REQ1 high: port 1 wins. Only REQ0 high: port 0 wins.
  - Both high: port 1 wins unless starvation count ≥ STARVE_LIMIT, in which case port 0 wins.
  - Counter increments when port 1 wins while REQ0 is high. It clears when port 0 wins or when REQ0 is low. It saturates at 15.
- ADDR:
  - Drive HSEL = 1, HTRANS = NONSEQ, HADDR, HWRITE, HSIZE.
  - Alignment: word clears addr[1:0]; halfword clears addr[0].
  - If HREADY = 1, go to DATA. If HREADY = 0, hold all address-phase outputs.
- DATA:
  - Drive HTRANS = IDLE, HSEL = 0, HWDATA = latched WDATA.
  - HREADY = 1 with HRESP = OKAY: capture HRDATA into the granted RDATA (reads only; RDATA is unchanged on writes) with ERR = 0; go to RESP.
  - HREADY = 1 with HRESP = ERROR: set ERR = 1 and leave RDATA unchanged; go to RESP.
  - HREADY = 0: wait, with no timeout. The first ERROR cycle (HREADY = 0) is ignored.
- RESP: ACK of the granted port is high for this single cycle, then go to IDLE.
- Requester handshake:
  - The requester updates REQ at the clock edge where it samples ACK.
  - A REQ still high in the cycle after ACK is a new request.
- Minimum latency: REQ seen in IDLE at cycle 0 → NONSEQ at cycle 1 → data phase at cycle 2 → ACK at cycle 3. Throughput is one transfer per 4 cycles when there are no wait states.
- Simultaneous events: a REQ change during ADDR, DATA or RESP has no effect until IDLE. The non-granted port's ACK stays 0.

Decomposition:
- Package sdram_arb_pkg: state enum; HTRANS_IDLE/HTRANS_NONSEQ; HRESP_OKAY/HRESP_ERROR; HBURST_SINGLE; size codes.
- One sub-module, sdram_arb_pick: combinational winner selection plus registered starvation counter.
- The FSM and datapath latches stay in the top level.

Test Plan:
- Single read: REQ1 = 1, ADDR1 = 0x000104, SIZE = 2, slave zero wait states, HRDATA = 0xDEADBEEF → NONSEQ at cycle 1 with HADDR = 0x00000104, ACK1 at cycle 3, RDATA1 = 0xDEADBEEF, ERR1 = 0.
- Halfword write alignment: REQ0, WE0 = 1, ADDR0 = 0x000033, SIZE = 1, WDATA = 0x12341234 → HADDR = 0x00000032, HSIZE = 1, HWDATA = 0x12341234 in the data phase, ACK0 = 1, RDATA0 unchanged.
- Wait states: slave holds HREADY = 0 for 2 ADDR cycles and 3 DATA cycles → address outputs stable throughout, ACK at cycle 8.
- Error response: HRESP = ERROR with HREADY = 0, then ERROR with HREADY = 1 → ACK1 = 1, ERR1 = 1, RDATA1 unchanged.
- Starvation: REQ0 and REQ1 both held high continuously, STARVE_LIMIT = 4 → grant sequence 1, 1, 1, 1, 0, 1, 1, 1, 1, 0.
- Reset during DATA: drop HRESETN while waiting on HREADY = 0 → all outputs 0 immediately, no ACK. After release, a pending REQ0 is issued with NONSEQ at cycle 1.
